// File: rtl/axis_qpsk_mod_pkg.sv
// Shared definitions for the AXI-Stream QPSK modulator: state codes, field widths,
// default constellation magnitude and the output sample packing.
package axis_qpsk_mod_pkg;

    localparam int SAMPLE_W  = 23;
    localparam int M_TDATA_W = 48;
    localparam int S_TDATA_W = 32;

    localparam logic [SAMPLE_W-1:0] AMP_DEFAULT = 23'd1448;

    localparam logic [0:0] S_READ  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } iq_t;

    // Each 23-bit component gets one sign-extension bit above it in the 48-bit beat.
    function automatic logic [M_TDATA_W-1:0] pack_iq(input iq_t s);
        return {s.im[SAMPLE_W-1], s.im, s.re[SAMPLE_W-1], s.re};
    endfunction

endpackage

// File: rtl/axis_qpsk_mod_if.sv
// Minimal AXI-Stream bundle (tdata/tvalid/tready/tlast) shared by the modulator ports.
interface axis_qpsk_mod_if
    import axis_qpsk_mod_pkg::*;
#(
    parameter int W = S_TDATA_W
) ();

    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/qpsk_mod.sv
// Combinational QPSK symbol mapper: bit 1 picks the sign of re, bit 0 the sign of im.
module qpsk_mod
    import axis_qpsk_mod_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] AMP = AMP_DEFAULT
) (
    input  logic        [1:0]          sym,
    output logic signed [SAMPLE_W-1:0] re,
    output logic signed [SAMPLE_W-1:0] im
);

    localparam logic signed [SAMPLE_W-1:0] POS = AMP;
    localparam logic signed [SAMPLE_W-1:0] NEG = -POS;

    assign re = sym[1] ? NEG : POS;
    assign im = sym[0] ? NEG : POS;

endmodule

// File: rtl/axis_qpsk_mod.sv
// AXI-Stream QPSK modulator: buffers FRAME_WORDS input words, then emits one
// complex sample per 2-bit symbol, MSB-first, with tlast on the final symbol.
module axis_qpsk_mod
    import axis_qpsk_mod_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] AMP         = AMP_DEFAULT,
    parameter int                  FRAME_WORDS = 2
) (
    input logic             aclk,
    input logic             areset,
    input logic             en,
    axis_qpsk_mod_if.slave  s_axis,
    axis_qpsk_mod_if.master m_axis
);

    localparam int SYMS  = 16 * FRAME_WORDS;
    localparam int RD_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int SYM_W = $clog2(SYMS);

    localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(FRAME_WORDS - 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMS - 1);

    logic [0:0]           state;
    logic [RD_W-1:0]      cnt_rd;
    logic [SYM_W-1:0]     cnt_sym;
    logic [S_TDATA_W-1:0] buffer [FRAME_WORDS];

    logic [S_TDATA_W-1:0]       cur_word;
    logic [4:0]                 sym_sh;
    logic [1:0]                 sym;
    logic signed [SAMPLE_W-1:0] map_re;
    logic signed [SAMPLE_W-1:0] map_im;
    iq_t                        iq;
    logic                       in_hs;
    logic                       out_hs;
    logic                       unused_tlast;

    assign unused_tlast = s_axis.tlast;

    // en only gates the first word; a started frame keeps ready high until complete.
    assign s_axis.tready = (state == S_READ) && (en || (cnt_rd != '0));
    assign in_hs         = s_axis.tvalid && s_axis.tready;

    assign m_axis.tvalid = (state == S_WRITE);
    assign m_axis.tlast  = (state == S_WRITE) && (cnt_sym == SYM_LAST);
    assign out_hs        = m_axis.tvalid && m_axis.tready;

    // Symbol 0 of each word sits in bits [31:30]; words are consumed in buffer order.
    assign cur_word = buffer[RD_W'(cnt_sym >> 4)];
    assign sym_sh   = 5'd30 - {cnt_sym[3:0], 1'b0};
    assign sym      = cur_word[sym_sh +: 2];

    qpsk_mod #(
        .AMP (AMP)
    ) u_map (
        .sym (sym),
        .re  (map_re),
        .im  (map_im)
    );

    assign iq.re         = map_re;
    assign iq.im         = map_im;
    assign m_axis.tdata  = pack_iq(iq);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= S_READ;
            cnt_rd  <= '0;
            cnt_sym <= '0;
            for (int i = 0; i < FRAME_WORDS; i++) begin
                buffer[i] <= '0;
            end
        end else if (state == S_READ) begin
            if (in_hs) begin
                buffer[cnt_rd] <= s_axis.tdata;
                if (cnt_rd == RD_LAST) begin
                    cnt_rd  <= '0;
                    cnt_sym <= '0;
                    state   <= S_WRITE;
                end else begin
                    cnt_rd <= cnt_rd + 1'b1;
                end
            end
        end else if (out_hs) begin
            if (cnt_sym == SYM_LAST) begin
                cnt_sym <= '0;
                state   <= S_READ;
            end else begin
                cnt_sym <= cnt_sym + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_qpsk_mod.sv
// Self-checking bench for axis_qpsk_mod: table-driven reference frame plus random
// frames checked against an arithmetic model and a sign-decision demodulator.
module tb_axis_qpsk_mod;

    localparam int AMP  = 1448;
    localparam int FW   = 2;
    localparam int SYMS = 16 * FW;

    logic aclk = 1'b0;
    logic areset;
    logic en;

    always #5 aclk = ~aclk;

    axis_qpsk_mod_if #(.W(32)) s_if ();
    axis_qpsk_mod_if #(.W(48)) m_if ();

    axis_qpsk_mod #(
        .AMP         (23'd1448),
        .FRAME_WORDS (FW)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .en     (en),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    typedef struct {
        logic [1:0]  sym;
        logic [47:0] exp;
    } vec_t;

    vec_t        tbl [4];
    logic [47:0] exp_s [SYMS];
    logic [1:0]  exp_sym [SYMS];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: symbol k is the k-th bit pair of the concatenated frame, MSB first.
    function automatic logic [1:0] model_sym(input logic [31:0] w0, input logic [31:0] w1, input int k);
        logic [63:0] fr;
        logic [63:0] t;
        fr = {w0, w1};
        t  = fr >> (62 - 2 * k);
        return t[1:0];
    endfunction

    function automatic logic [47:0] model_sample(input logic [1:0] s);
        logic [23:0] re24;
        logic [23:0] im24;
        re24 = s[1] ? 24'(-AMP) : 24'(AMP);
        im24 = s[0] ? 24'(-AMP) : 24'(AMP);
        return {im24, re24};
    endfunction

    task automatic set_exp(input logic [31:0] w0, input logic [31:0] w1);
        for (int k = 0; k < SYMS; k++) begin
            exp_sym[k] = model_sym(w0, w1, k);
            exp_s[k]   = model_sample(exp_sym[k]);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        s_if.tdata  = w;
        s_if.tvalid = 1'b1;
        while (!done && waits < 20) begin
            #1;
            if (s_if.tready) done = 1'b1;
            else waits++;
            step();
        end
        s_if.tvalid = 1'b0;
        check("send_accept", done, 1);
    endtask

    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1);
        int wt;
        send_word(w0, wt);
        send_word(w1, wt);
    endtask

    // mode 0: ready always, 1: toggling, 2: random. junk keeps a word offered meanwhile.
    task automatic collect(input int mode, input int nmax, input bit junk);
        int          k;
        int          guard;
        bit          stalled;
        logic [47:0] pd;
        logic        pl;
        k       = 0;
        guard   = 0;
        stalled = 1'b0;
        pd      = '0;
        pl      = 1'b0;
        if (junk) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'hDEADBEEF;
        end
        while (k < nmax && guard < 40 * SYMS) begin
            case (mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = (guard % 2 == 0);
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
            #1;
            check("m_tvalid_in_frame", m_if.tvalid, 1);
            check("s_tready_in_write", s_if.tready, 0);
            if (stalled) begin
                check("stall_data_stable", m_if.tdata, pd);
                check("stall_tlast_stable", m_if.tlast, pl);
            end
            if (m_if.tready) begin
                check("sample_data", m_if.tdata, exp_s[k]);
                check("demod_symbol", {m_if.tdata[22], m_if.tdata[46]}, exp_sym[k]);
                check("sample_tlast", m_if.tlast, (k == SYMS - 1));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pd      = m_if.tdata;
                pl      = m_if.tlast;
            end
            guard++;
            step();
        end
        check("collect_count", k, nmax);
        m_if.tready = 1'b0;
        if (junk) s_if.tvalid = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
        $fatal(1);
    end

    initial begin
        int          wt;
        logic [31:0] w0;
        logic [31:0] w1;

        tbl[0] = '{2'b00, 48'h0005A8_0005A8};
        tbl[1] = '{2'b01, 48'hFFFA58_0005A8};
        tbl[2] = '{2'b10, 48'h0005A8_FFFA58};
        tbl[3] = '{2'b11, 48'hFFFA58_FFFA58};

        areset      = 1'b1;
        en          = 1'b1;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        step();
        step();
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tlast", m_if.tlast, 0);
        check("rst_s_tready_en1", s_if.tready, 1);
        en = 1'b0;
        #1;
        check("rst_s_tready_en0", s_if.tready, 0);
        en = 1'b1;
        areset = 1'b0;
        step();

        // Reference frame checked against the fixed constellation table.
        for (int k = 0; k < SYMS; k++) begin
            exp_s[k]   = tbl[k % 4].exp;
            exp_sym[k] = tbl[k % 4].sym;
        end
        send_word(32'h1B1B1B1B, wt);
        check("first_word_no_wait", wt, 0);
        s_if.tlast = 1'b1;
        send_word(32'h1B1B1B1B, wt);
        s_if.tlast = 1'b0;
        collect(0, SYMS, 1'b0);
        #1;
        check("post_frame_m_tvalid", m_if.tvalid, 0);
        check("post_frame_s_tready", s_if.tready, 1);

        // Same frame under toggling back-pressure, with a junk word offered throughout.
        send_frame(32'h1B1B1B1B, 32'h1B1B1B1B);
        collect(1, SYMS, 1'b1);

        // en low in idle blocks the frame start.
        w0 = $urandom;
        w1 = $urandom;
        en = 1'b0;
        s_if.tdata  = 32'h12345678;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_en0_s_tready", s_if.tready, 0);
            check("idle_en0_m_tvalid", m_if.tvalid, 0);
            step();
        end
        en = 1'b1;
        send_word(w0, wt);
        en = 1'b0;
        send_word(w1, wt);
        check("word1_with_en0_no_wait", wt, 0);
        set_exp(w0, w1);
        collect(2, SYMS, 1'b0);
        en = 1'b1;

        // Back-to-back frames: the next word must go in right after the tlast handshake.
        set_exp(32'h00000000, 32'h00000000);
        send_frame(32'h00000000, 32'h00000000);
        collect(0, SYMS, 1'b0);
        set_exp(32'hFFFFFFFF, 32'hFFFFFFFF);
        send_word(32'hFFFFFFFF, wt);
        check("b2b_first_word_no_wait", wt, 0);
        send_word(32'hFFFFFFFF, wt);
        collect(0, SYMS, 1'b0);

        // Reset at sample 10 discards the rest of the frame.
        w0 = $urandom;
        w1 = $urandom;
        set_exp(w0, w1);
        send_frame(w0, w1);
        collect(0, 10, 1'b0);
        areset = 1'b1;
        step();
        check("midrst_m_tvalid", m_if.tvalid, 0);
        check("midrst_m_tlast", m_if.tlast, 0);
        check("midrst_s_tready", s_if.tready, 1);
        areset = 1'b0;
        m_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("midrst_no_stale_sample", m_if.tvalid, 0);
            step();
        end
        m_if.tready = 1'b0;
        w0 = $urandom;
        w1 = $urandom;
        set_exp(w0, w1);
        send_frame(w0, w1);
        collect(0, SYMS, 1'b0);

        // Random frames, random back-pressure, demodulated symbols compared each sample.
        for (int f = 0; f < 6; f++) begin
            w0 = $urandom;
            w1 = $urandom;
            set_exp(w0, w1);
            send_frame(w0, w1);
            collect(2, SYMS, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
